// File: rtl/core_pkg.sv
// Shared types and encodings for the TTL RISC-V multi-cycle control path:
// sequencer states, opcode classes, datapath mux encodings and mcause codes.
package core_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_TRAP   = 3'd4
    } state_e;

    // inst[6:2] opcode classes
    localparam logic [4:0] OPC_OP       = 5'b01100;
    localparam logic [4:0] OPC_OP_IMM   = 5'b00100;
    localparam logic [4:0] OPC_LUI      = 5'b01101;
    localparam logic [4:0] OPC_AUIPC    = 5'b00101;
    localparam logic [4:0] OPC_JAL      = 5'b11011;
    localparam logic [4:0] OPC_JALR     = 5'b11001;
    localparam logic [4:0] OPC_BRANCH   = 5'b11000;
    localparam logic [4:0] OPC_LOAD     = 5'b00000;
    localparam logic [4:0] OPC_STORE    = 5'b01000;
    localparam logic [4:0] OPC_MISC_MEM = 5'b00011;
    localparam logic [4:0] OPC_SYSTEM   = 5'b11100;

    localparam logic [1:0] PC_SEL_PLUS4  = 2'd0;
    localparam logic [1:0] PC_SEL_TARGET = 2'd1;
    localparam logic [1:0] PC_SEL_MTVEC  = 2'd2;
    localparam logic [1:0] PC_SEL_MEPC   = 2'd3;

    localparam logic [1:0] WB_SEL_ALU  = 2'd0;
    localparam logic [1:0] WB_SEL_LOAD = 2'd1;
    localparam logic [1:0] WB_SEL_PC4  = 2'd2;
    localparam logic [1:0] WB_SEL_IMM  = 2'd3;

    localparam logic [3:0] CAUSE_INST_MISALIGN  = 4'd0;
    localparam logic [3:0] CAUSE_INST_ACCESS    = 4'd1;
    localparam logic [3:0] CAUSE_ILLEGAL        = 4'd2;
    localparam logic [3:0] CAUSE_BREAKPOINT     = 4'd3;
    localparam logic [3:0] CAUSE_LOAD_MISALIGN  = 4'd4;
    localparam logic [3:0] CAUSE_LOAD_ACCESS    = 4'd5;
    localparam logic [3:0] CAUSE_STORE_MISALIGN = 4'd6;
    localparam logic [3:0] CAUSE_STORE_ACCESS   = 4'd7;
    localparam logic [3:0] CAUSE_ECALL_M        = 4'd11;

    // Halfword (x01) needs bit 0 clear; word (010) needs both low bits clear.
    function automatic logic data_misaligned(input logic [2:0] func3, input logic [1:0] addr_lsb);
        return ((func3[1:0] == 2'b01) && addr_lsb[0]) ||
               ((func3 == 3'b010) && (addr_lsb != 2'b00));
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Saturating wait counter for the shared memory handshake; flags a timeout
// once the request has been pending for MAX_WAIT cycles.
module mem_wait_timer #(
    parameter int MAX_WAIT = 255,
    parameter int WAIT_W   = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic timeout
);

    localparam logic [WAIT_W-1:0] MAX_CNT = WAIT_W'(MAX_WAIT);

    logic [WAIT_W-1:0] cnt_q, cnt_d;

    assign timeout = (cnt_q == MAX_CNT);

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && !timeout) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only; the next
    // value is computed in always_comb so no latch or race can creep in.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/exec_sequencer.sv
// Multi-cycle fetch/decode/exec/mem/trap control FSM for the TTL RISC-V core.
// Build option: define MISALIGN_TRAP_EN to trap misaligned jumps and data accesses in EXEC.
module exec_sequencer
    import core_pkg::*;
#(
    parameter int MAX_WAIT = 255,
    parameter int WAIT_W   = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] opcode,
    input  logic [2:0] func3,
    input  logic       ecall,
    input  logic       ebreak,
    input  logic       mret,
    input  logic       invalid,
    input  logic       br_taken,
    input  logic [1:0] addr_lsb,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_we,
    output logic       mem_fetch,
    output logic       ir_we,
    output logic       pc_we,
    output logic [1:0] pc_sel,
    output logic       rf_we,
    output logic [1:0] wb_sel,
    output logic       mepc_we,
    output logic       trap,
    output logic [3:0] trap_cause,
    output logic       retire
);

    state_e     state_q, state_d;
    logic [3:0] cause_q, cause_d;

    logic       timeout;
    logic       wait_clr;
    logic       wait_inc;

    logic       req_c, we_c, fetch_c, ir_we_c, pc_we_c, rf_we_c;
    logic       mepc_we_c, trap_c, retire_c;
    logic [1:0] pc_sel_c, wb_sel_c;

    logic       mis_hit;
    logic [3:0] mis_cause;

`ifdef MISALIGN_TRAP_EN
    always_comb begin
        mis_hit   = 1'b0;
        mis_cause = CAUSE_INST_MISALIGN;
        case (opcode)
            OPC_JAL, OPC_JALR: mis_hit = addr_lsb[1];
            OPC_BRANCH:        mis_hit = br_taken && addr_lsb[1];
            OPC_LOAD: begin
                mis_hit   = data_misaligned(func3, addr_lsb);
                mis_cause = CAUSE_LOAD_MISALIGN;
            end
            OPC_STORE: begin
                mis_hit   = data_misaligned(func3, addr_lsb);
                mis_cause = CAUSE_STORE_MISALIGN;
            end
            default: ;
        endcase
    end
`else
    logic unused_align_inputs;
    assign unused_align_inputs = ^{func3, addr_lsb};
    assign mis_hit   = 1'b0;
    assign mis_cause = CAUSE_INST_MISALIGN;
`endif

    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d   = state_q;
        cause_d   = cause_q;
        wait_inc  = 1'b0;
        req_c     = 1'b0;
        we_c      = 1'b0;
        fetch_c   = 1'b0;
        ir_we_c   = 1'b0;
        pc_we_c   = 1'b0;
        pc_sel_c  = PC_SEL_PLUS4;
        rf_we_c   = 1'b0;
        wb_sel_c  = WB_SEL_ALU;
        mepc_we_c = 1'b0;
        trap_c    = 1'b0;
        retire_c  = 1'b0;

        unique case (state_q)
            ST_FETCH: begin
                if (timeout) begin
                    state_d = ST_TRAP;
                    cause_d = CAUSE_INST_ACCESS;
                end else begin
                    req_c   = 1'b1;
                    fetch_c = 1'b1;
                    if (mem_ready) begin
                        ir_we_c = 1'b1;
                        state_d = ST_DECODE;
                    end else begin
                        wait_inc = 1'b1;
                    end
                end
            end

            ST_DECODE: begin
                if (invalid) begin
                    state_d = ST_TRAP;
                    cause_d = CAUSE_ILLEGAL;
                end else if (ecall) begin
                    state_d = ST_TRAP;
                    cause_d = CAUSE_ECALL_M;
                end else if (ebreak) begin
                    state_d = ST_TRAP;
                    cause_d = CAUSE_BREAKPOINT;
                end else if (mret) begin
                    pc_sel_c = PC_SEL_MEPC;
                    pc_we_c  = 1'b1;
                    retire_c = 1'b1;
                    state_d  = ST_FETCH;
                end else begin
                    state_d = ST_EXEC;
                end
            end

            ST_EXEC: begin
                state_d  = ST_FETCH;
                pc_we_c  = 1'b1;
                retire_c = 1'b1;
                case (opcode)
                    OPC_OP, OPC_OP_IMM, OPC_AUIPC: begin
                        rf_we_c  = 1'b1;
                        wb_sel_c = WB_SEL_ALU;
                    end
                    OPC_LUI: begin
                        rf_we_c  = 1'b1;
                        wb_sel_c = WB_SEL_IMM;
                    end
                    OPC_JAL, OPC_JALR: begin
                        rf_we_c  = 1'b1;
                        wb_sel_c = WB_SEL_PC4;
                        pc_sel_c = PC_SEL_TARGET;
                    end
                    OPC_BRANCH: pc_sel_c = br_taken ? PC_SEL_TARGET : PC_SEL_PLUS4;
                    OPC_LOAD, OPC_STORE: begin
                        pc_we_c  = 1'b0;
                        retire_c = 1'b0;
                        state_d  = ST_MEM;
                    end
                    default: ;
                endcase
                // A misaligned target or address suppresses every commit of this instruction.
                if (mis_hit) begin
                    rf_we_c  = 1'b0;
                    pc_we_c  = 1'b0;
                    retire_c = 1'b0;
                    pc_sel_c = PC_SEL_PLUS4;
                    wb_sel_c = WB_SEL_ALU;
                    state_d  = ST_TRAP;
                    cause_d  = mis_cause;
                end
            end

            ST_MEM: begin
                if (timeout) begin
                    state_d = ST_TRAP;
                    cause_d = (opcode == OPC_STORE) ? CAUSE_STORE_ACCESS : CAUSE_LOAD_ACCESS;
                end else begin
                    req_c = 1'b1;
                    we_c  = (opcode == OPC_STORE);
                    if (mem_ready) begin
                        rf_we_c  = (opcode != OPC_STORE);
                        wb_sel_c = WB_SEL_LOAD;
                        pc_sel_c = PC_SEL_PLUS4;
                        pc_we_c  = 1'b1;
                        retire_c = 1'b1;
                        state_d  = ST_FETCH;
                    end else begin
                        wait_inc = 1'b1;
                    end
                end
            end

            ST_TRAP: begin
                trap_c    = 1'b1;
                mepc_we_c = 1'b1;
                pc_sel_c  = PC_SEL_MTVEC;
                pc_we_c   = 1'b1;
                state_d   = ST_FETCH;
            end

            default: state_d = ST_FETCH;
        endcase
    end

    // The counter restarts on any state change, on ready, and outside memory states.
    assign wait_clr = (state_d != state_q) || mem_ready ||
                      !((state_q == ST_FETCH) || (state_q == ST_MEM));

    mem_wait_timer #(
        .MAX_WAIT (MAX_WAIT),
        .WAIT_W   (WAIT_W)
    ) u_wait (
        .clk     (clk),
        .rst     (rst),
        .clr     (wait_clr),
        .inc     (wait_inc),
        .timeout (timeout)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_FETCH;
            cause_q <= 4'd0;
        end else begin
            state_q <= state_d;
            cause_q <= cause_d;
        end
    end

    // Reset forces every strobe low at once, so an in-flight access is abandoned.
    assign mem_req    = req_c     && !rst;
    assign mem_we     = we_c      && !rst;
    assign mem_fetch  = fetch_c   && !rst;
    assign ir_we      = ir_we_c   && !rst;
    assign pc_we      = pc_we_c   && !rst;
    assign rf_we      = rf_we_c   && !rst;
    assign mepc_we    = mepc_we_c && !rst;
    assign trap       = trap_c    && !rst;
    assign retire     = retire_c  && !rst;
    assign pc_sel     = rst ? PC_SEL_PLUS4 : pc_sel_c;
    assign wb_sel     = rst ? WB_SEL_ALU : wb_sel_c;
    assign trap_cause = trap ? cause_q : 4'd0;

endmodule

// File: tb/tb_exec_sequencer.sv
// Directed self-checking bench for exec_sequencer (MAX_WAIT=4) using an expected-output queue.
module tb_exec_sequencer;

    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic       mem_fetch;
        logic       ir_we;
        logic       pc_we;
        logic [1:0] pc_sel;
        logic       rf_we;
        logic [1:0] wb_sel;
        logic       mepc_we;
        logic       trap;
        logic [3:0] trap_cause;
        logic       retire;
    } out_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] opcode;
    logic [2:0] func3;
    logic       ecall, ebreak, mret, invalid, br_taken;
    logic [1:0] addr_lsb;
    logic       mem_ready;
    logic       mem_req, mem_we, mem_fetch, ir_we, pc_we, rf_we, mepc_we, trap, retire;
    logic [1:0] pc_sel, wb_sel;
    logic [3:0] trap_cause;

    int   n_cmp = 0;
    int   n_err = 0;
    out_t exp_q[$];
    string tag_q[$];

    always #5 clk = ~clk;

    exec_sequencer #(.MAX_WAIT(4), .WAIT_W(3)) dut (
        .clk        (clk),
        .rst        (rst),
        .opcode     (opcode),
        .func3      (func3),
        .ecall      (ecall),
        .ebreak     (ebreak),
        .mret       (mret),
        .invalid    (invalid),
        .br_taken   (br_taken),
        .addr_lsb   (addr_lsb),
        .mem_ready  (mem_ready),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_fetch  (mem_fetch),
        .ir_we      (ir_we),
        .pc_we      (pc_we),
        .pc_sel     (pc_sel),
        .rf_we      (rf_we),
        .wb_sel     (wb_sel),
        .mepc_we    (mepc_we),
        .trap       (trap),
        .trap_cause (trap_cause),
        .retire     (retire)
    );

    function automatic out_t o(input logic req, input logic we, input logic fe, input logic ir,
                               input logic pcw, input logic [1:0] pcs, input logic rfw,
                               input logic [1:0] wbs, input logic mep, input logic tr,
                               input logic [3:0] cau, input logic ret);
        return '{req, we, fe, ir, pcw, pcs, rfw, wbs, mep, tr, cau, ret};
    endfunction

    function automatic out_t trap_vec(input logic [3:0] cause);
        return o(0, 0, 0, 0, 1, 2'd2, 0, 2'd0, 1, 1, cause, 0);
    endfunction

    localparam out_t IDLE   = '0;
    localparam out_t F_WAIT = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 1'b0, 4'd0, 1'b0};
    localparam out_t F_RDY  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 1'b0, 4'd0, 1'b0};

    // Queue the expectation for this cycle, compare at the falling edge, then advance.
    task automatic step(input string tag, input out_t exp);
        out_t  obs, e;
        string t;
        exp_q.push_back(exp);
        tag_q.push_back(tag);
        @(negedge clk);
        obs = {mem_req, mem_we, mem_fetch, ir_we, pc_we, pc_sel, rf_we, wb_sel,
               mepc_we, trap, trap_cause, retire};
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        n_cmp++;
        assert (obs === e) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", t, obs, e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_dec(input logic [4:0] opc, input logic [2:0] f3, input logic inv,
                           input logic ec, input logic eb, input logic mr);
        opcode  = opc;
        func3   = f3;
        invalid = inv;
        ecall   = ec;
        ebreak  = eb;
        mret    = mr;
    endtask

    task automatic fetch_decode(input string tag);
        mem_ready = 1'b1;
        step({tag, "_fetch"}, F_RDY);
        mem_ready = 1'b0;
        step({tag, "_decode"}, IDLE);
    endtask

    initial begin
        rst = 1'b1; mem_ready = 1'b0; br_taken = 1'b0; addr_lsb = 2'b00;
        set_dec(5'b00100, 3'b000, 0, 0, 0, 0);
        step("reset_quiet", IDLE);
        rst = 1'b0;

        // ADDI with mem_ready ignored in DECODE
        mem_ready = 1'b1;
        step("addi_fetch", F_RDY);
        step("addi_decode_ready_ignored", IDLE);
        mem_ready = 1'b0;
        step("addi_exec", o(0, 0, 0, 0, 1, 2'd0, 1, 2'd0, 0, 0, 4'd0, 1));
        step("addi_next_fetch", F_WAIT);

        set_dec(5'b11000, 3'b000, 0, 0, 0, 0);
        fetch_decode("beq_t");
        br_taken = 1'b1;
        step("beq_taken_exec", o(0, 0, 0, 0, 1, 2'd1, 0, 2'd0, 0, 0, 4'd0, 1));
        fetch_decode("beq_nt");
        br_taken = 1'b0;
        step("beq_not_taken_exec", o(0, 0, 0, 0, 1, 2'd0, 0, 2'd0, 0, 0, 4'd0, 1));

        set_dec(5'b01101, 3'b000, 0, 0, 0, 0);
        fetch_decode("lui");
        step("lui_exec", o(0, 0, 0, 0, 1, 2'd0, 1, 2'd3, 0, 0, 4'd0, 1));

        // LW: ready arrives on the fourth MEM cycle
        set_dec(5'b00000, 3'b010, 0, 0, 0, 0);
        fetch_decode("lw");
        step("lw_exec", IDLE);
        for (int i = 0; i < 3; i++) step("lw_mem_wait", o(1, 0, 0, 0, 0, 2'd0, 0, 2'd0, 0, 0, 4'd0, 0));
        mem_ready = 1'b1;
        step("lw_mem_ready", o(1, 0, 0, 0, 1, 2'd0, 1, 2'd1, 0, 0, 4'd0, 1));
        mem_ready = 1'b0;

        // SW never acknowledged: four request cycles, then drop and trap
        set_dec(5'b01000, 3'b010, 0, 0, 0, 0);
        fetch_decode("sw");
        step("sw_exec", IDLE);
        for (int i = 0; i < 4; i++) step("sw_mem_wait", o(1, 1, 0, 0, 0, 2'd0, 0, 2'd0, 0, 0, 4'd0, 0));
        step("sw_timeout_drop", IDLE);
        step("sw_trap", trap_vec(4'd7));
        step("sw_after_trap_fetch", F_WAIT);

        // Fetch timeout: the cycle above was the first wait
        for (int i = 0; i < 3; i++) step("fetch_wait", F_WAIT);
        step("fetch_timeout_drop", IDLE);
        step("fetch_trap", trap_vec(4'd1));

        set_dec(5'b11100, 3'b000, 1, 1, 0, 0);
        fetch_decode("inv_ecall");
        step("inv_ecall_trap", trap_vec(4'd2));
        set_dec(5'b11100, 3'b000, 0, 1, 0, 0);
        fetch_decode("ecall");
        step("ecall_trap", trap_vec(4'd11));
        set_dec(5'b11100, 3'b000, 0, 0, 1, 0);
        fetch_decode("ebreak");
        step("ebreak_trap", trap_vec(4'd3));

        set_dec(5'b11100, 3'b000, 0, 0, 0, 1);
        mem_ready = 1'b1;
        step("mret_fetch", F_RDY);
        mem_ready = 1'b0;
        step("mret_decode", o(0, 0, 0, 0, 1, 2'd3, 0, 2'd0, 0, 0, 4'd0, 1));
        step("mret_next_fetch", F_WAIT);

        // JAL and LH with low address bits set
        set_dec(5'b11011, 3'b000, 0, 0, 0, 0);
        addr_lsb = 2'b10;
        fetch_decode("jal_mis");
`ifdef MISALIGN_TRAP_EN
        step("jal_mis_exec", IDLE);
        step("jal_mis_trap", trap_vec(4'd0));
`else
        step("jal_mis_exec", o(0, 0, 0, 0, 1, 2'd1, 1, 2'd2, 0, 0, 4'd0, 1));
`endif
        set_dec(5'b00000, 3'b001, 0, 0, 0, 0);
        addr_lsb = 2'b01;
        fetch_decode("lh_mis");
        step("lh_mis_exec", IDLE);
`ifdef MISALIGN_TRAP_EN
        step("lh_mis_trap", trap_vec(4'd4));
`else
        mem_ready = 1'b1;
        step("lh_mis_mem", o(1, 0, 0, 0, 1, 2'd0, 1, 2'd1, 0, 0, 4'd0, 1));
        mem_ready = 1'b0;
`endif
        addr_lsb = 2'b00;

        // Reset asserted mid-store drops every strobe immediately
        set_dec(5'b01000, 3'b010, 0, 0, 0, 0);
        fetch_decode("sw_rst");
        step("sw_rst_exec", IDLE);
        step("sw_rst_mem", o(1, 1, 0, 0, 0, 2'd0, 0, 2'd0, 0, 0, 4'd0, 0));
        rst = 1'b1;
        mem_ready = 1'b1;
        step("sw_rst_async_drop", IDLE);
        rst = 1'b0;
        mem_ready = 1'b0;
        step("post_reset_fetch", F_WAIT);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
